toll_lane_ctrl: RTL

//  Parametrised toll-lane controller, successor of the fixed 3-sensor speed/barrier path.

---
 rtl/toll_lane_ctrl.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/toll_lane_ctrl.sv
// Toll-lane controller: tracks vehicles across NUM_SENSORS roadside sensors, times them in ms,
// drives the barrier from E-pass/manual enable and emits one record per vehicle.
module toll_lane_ctrl #(
  parameter int SYS_FREQ    = 10_000_000,
  parameter int NUM_SENSORS = 3,
  parameter int EPASS_IDX   = 1,
  parameter int WIDTH_MS    = 16,
  parameter int MIN_SEG_MS  = 300,
  parameter int TIMEOUT_MS  = 5000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_SENSORS-1:0] sensor,
  input  logic [1:0]             valid_Epass,
  input  logic                   enable,
  output logic                   barrier,
  output logic                   rec_valid,
  input  logic                   rec_ready,
  output logic [WIDTH_MS-1:0]    rec_total_ms,
  output logic                   rec_overspeed,
  output logic [1:0]             rec_status,
  output logic                   rec_drop,
  output logic [1:0]             fsm_state
);

  localparam int PRESC = SYS_FREQ / 1000;
  localparam int PW    = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int IW    = $clog2(NUM_SENSORS);

  localparam logic [PW-1:0]       PRESC_MAX = PW'(PRESC - 1);
  localparam logic [IW-1:0]       LAST_IDX  = IW'(NUM_SENSORS - 1);
  localparam logic [IW-1:0]       ONE_IDX   = IW'(1);
  localparam logic [WIDTH_MS-1:0] MIN_SEG   = WIDTH_MS'(MIN_SEG_MS);
  localparam logic [WIDTH_MS-1:0] TIMEOUT   = WIDTH_MS'(TIMEOUT_MS);
  localparam logic [WIDTH_MS-1:0] MS_MAX    = '1;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] TRACK = 2'b01;
  localparam logic [1:0] EXIT  = 2'b10;

  logic [NUM_SENSORS-1:0] sen_m, sen_s, sen_d, sen_rise;
  logic                   last_fall;
  logic [1:0]             ep_m, ep_s;
  logic                   en_m, en_s;

  logic [PW-1:0]       presc;
  logic                tick;
  logic [1:0]          state;
  logic [IW-1:0]       idx;
  logic [WIDTH_MS-1:0] ms_cnt, seg_cnt, pend_cnt, total_q;
  logic [WIDTH_MS-1:0] ms_inc, seg_inc, pend_inc;
  logic                paid, rej, man, ovs, pending, tail_rise;

  logic                bld_valid, bld_ovs;
  logic [WIDTH_MS-1:0] bld_total;
  logic [1:0]          bld_status;

  // Two sync flops, then one registered edge stage: a pin change becomes an event 3 clocks later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sen_m     <= '0;
      sen_s     <= '0;
      sen_d     <= '0;
      sen_rise  <= '0;
      last_fall <= 1'b0;
      ep_m      <= 2'b00;
      ep_s      <= 2'b00;
      en_m      <= 1'b0;
      en_s      <= 1'b0;
    end else begin
      sen_m     <= sensor;
      sen_s     <= sen_m;
      sen_d     <= sen_s;
      sen_rise  <= sen_s & ~sen_d;
      last_fall <= ~sen_s[NUM_SENSORS-1] & sen_d[NUM_SENSORS-1];
      ep_m      <= valid_Epass;
      ep_s      <= ep_m;
      en_m      <= enable;
      en_s      <= en_m;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) presc <= '0;
    else          presc <= (presc == PRESC_MAX) ? '0 : presc + 1'b1;
  end

  assign tick      = (presc == PRESC_MAX);
  assign ms_inc    = (tick && ms_cnt   != MS_MAX) ? ms_cnt   + 1'b1 : ms_cnt;
  assign seg_inc   = (tick && seg_cnt  != MS_MAX) ? seg_cnt  + 1'b1 : seg_cnt;
  assign pend_inc  = (tick && pend_cnt != MS_MAX) ? pend_cnt + 1'b1 : pend_cnt;
  // A following car is only recognised once the current one has passed sensor[1].
  assign tail_rise = sen_rise[0] && !pending && (state == EXIT || idx > ONE_IDX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      idx        <= ONE_IDX;
      ms_cnt     <= '0;
      seg_cnt    <= '0;
      pend_cnt   <= '0;
      total_q    <= '0;
      paid       <= 1'b0;
      rej        <= 1'b0;
      man        <= 1'b0;
      ovs        <= 1'b0;
      pending    <= 1'b0;
      bld_valid  <= 1'b0;
      bld_total  <= '0;
      bld_ovs    <= 1'b0;
      bld_status <= 2'b00;
    end else begin
      bld_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (sen_rise[0]) begin
            state   <= TRACK;
            ms_cnt  <= '0;
            seg_cnt <= '0;
            idx     <= ONE_IDX;
            paid    <= 1'b0;
            rej     <= 1'b0;
            man     <= 1'b0;
            ovs     <= 1'b0;
            pending <= 1'b0;
          end
        end
        TRACK, EXIT: begin
          ms_cnt  <= ms_inc;
          seg_cnt <= seg_inc;
          if (pending) pend_cnt <= pend_inc;
          if (en_s) man <= 1'b1;
          if (tail_rise) begin
            pending  <= 1'b1;
            pend_cnt <= '0;
          end
          if (seg_inc >= TIMEOUT) begin
            bld_valid  <= 1'b1;
            bld_total  <= (state == EXIT) ? total_q : ms_inc;
            bld_ovs    <= ovs;
            bld_status <= 2'b11;
            paid       <= 1'b0;
            pending    <= 1'b0;
            state      <= IDLE;
          end else if (state == TRACK) begin
            // First decisive E-pass code wins for this vehicle.
            if (sen_s[EPASS_IDX] && !paid && !rej) begin
              if (ep_s == 2'b10)      paid <= 1'b1;
              else if (ep_s == 2'b11) rej  <= 1'b1;
            end
            if (sen_rise[idx]) begin
              ovs     <= ovs | (seg_inc < MIN_SEG);
              seg_cnt <= '0;
              if (idx == LAST_IDX) begin
                total_q <= ms_inc;
                state   <= EXIT;
              end else begin
                idx <= idx + 1'b1;
              end
            end
          end else if (last_fall) begin
            bld_valid  <= 1'b1;
            bld_total  <= total_q;
            bld_ovs    <= ovs;
            bld_status <= paid ? 2'b00 : (man ? 2'b01 : 2'b10);
            paid       <= 1'b0;
            rej        <= 1'b0;
            man        <= 1'b0;
            ovs        <= 1'b0;
            idx        <= ONE_IDX;
            pending    <= 1'b0;
            if (pending) begin
              state   <= TRACK;
              ms_cnt  <= pend_inc;
              seg_cnt <= pend_inc;
            end else if (tail_rise) begin
              state   <= TRACK;
              ms_cnt  <= '0;
              seg_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Record handshake: a record transfers on a clock where rec_valid and rec_ready are both high;
  // fields hold while rec_valid is high, and rec_valid is never withdrawn without a transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rec_valid     <= 1'b0;
      rec_total_ms  <= '0;
      rec_overspeed <= 1'b0;
      rec_status    <= 2'b00;
      rec_drop      <= 1'b0;
    end else begin
      rec_drop <= 1'b0;
      if (bld_valid) begin
        if (!rec_valid || rec_ready) begin
          rec_valid     <= 1'b1;
          rec_total_ms  <= bld_total;
          rec_overspeed <= bld_ovs;
          rec_status    <= bld_status;
        end else begin
          rec_drop <= 1'b1;
        end
      end else if (rec_valid && rec_ready) begin
        rec_valid <= 1'b0;
      end
    end
  end

  assign barrier   = paid | en_s;
  assign fsm_state = state;

endmodule
